// File: rtl/gmii_tx_arbiter.sv
// ---------------------------------------------------------------------------
// gmii_tx_arbiter
//   Frame-atomic round-robin arbiter in front of the GMII TX serializer.
//   One source owns the datapath for a whole frame. Every frame is followed
//   by an inter-packet gap. A stall watchdog drops a granted source that
//   stops supplying bytes mid-frame.
//
// Ports
//   CLK      125 MHz TX clock, rising edge
//   RST      asynchronous active-low reset
//   i_valid  per-source byte valid            [NUM_REQ]
//   i_data   per-source byte, src k at [k*DATA_W +: DATA_W]
//   i_last   per-source end of frame (qualified by i_valid)
//   o_ready  per-source ready, only the granted bit can be set
//   o_valid  merged stream valid to gmii_tx
//   o_data   merged stream byte
//   o_last   merged stream last
//   i_ready  gmii_tx ready
//   o_grant  one-hot grant, zero outside XFER
//   o_abort  one-cycle pulse on watchdog abort
//   o_busy   high in XFER or IFG
// ---------------------------------------------------------------------------
module gmii_tx_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_W     = 8,
   parameter int IFG_CYCLES = 12,
   parameter int STALL_MAX  = 64
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [NUM_REQ-1:0]          i_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   i_data,
   input  logic [NUM_REQ-1:0]          i_last,
   output logic [NUM_REQ-1:0]          o_ready,
   output logic                        o_valid,
   output logic [DATA_W-1:0]           o_data,
   output logic                        o_last,
   input  logic                        i_ready,
   output logic [NUM_REQ-1:0]          o_grant,
   output logic                        o_abort,
   output logic                        o_busy
);

   localparam int PTR_W   = $clog2(NUM_REQ);
   localparam int STALL_W = $clog2(STALL_MAX + 1);
   localparam int GAP_W   = $clog2(IFG_CYCLES + 1);

   // Compare against MAX-1 so the expiring cycle itself completes the count.
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);
   localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(IFG_CYCLES - 1);
   localparam logic [PTR_W-1:0]   PTR_TOP    = PTR_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_IFG} state_t;

   state_t               r_state, w_state_nxt;
   logic [PTR_W-1:0]     r_ptr,   w_ptr_nxt;
   logic [PTR_W-1:0]     r_gidx,  w_gidx_nxt;
   logic [STALL_W-1:0]   r_stall, w_stall_nxt;
   logic [GAP_W-1:0]     r_gap,   w_gap_nxt;
   logic                 r_abort, w_abort_nxt;

   logic                 w_xfer;
   logic [NUM_REQ-1:0]   w_onehot;
   logic                 w_gvalid;
   logic                 w_beat;
   logic [PTR_W-1:0]     w_ptr_inc;
   logic [DATA_W-1:0]    w_bytes [NUM_REQ];
   logic [2*NUM_REQ-1:0] w_req2;
   logic [NUM_REQ-1:0]   w_rot;
   logic                 w_req_any;
   logic [PTR_W-1:0]     w_req_idx;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_byte
      assign w_bytes[k] = i_data[k*DATA_W +: DATA_W];
   end

   // Datapath mux: combinational from the registered grant index.
   assign w_xfer    = (r_state == S_XFER);
   assign w_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_gidx;
   assign w_gvalid  = i_valid[r_gidx];
   assign o_valid   = w_xfer & w_gvalid;
   assign o_data    = w_xfer ? w_bytes[r_gidx] : '0;
   assign o_last    = w_xfer & w_gvalid & i_last[r_gidx];
   assign o_ready   = (w_xfer & i_ready) ? w_onehot : '0;
   assign o_grant   = w_xfer ? w_onehot : '0;
   assign o_busy    = (r_state != S_IDLE);
   assign o_abort   = r_abort;
   assign w_beat    = o_valid & i_ready;
   assign w_ptr_inc = (r_gidx == PTR_TOP) ? '0 : r_gidx + 1'b1;

   // Round-robin search: rotate the request vector so rr_ptr sits at bit 0,
   // then the lowest set bit is the winner; map back modulo NUM_REQ.
   assign w_req2 = {i_valid, i_valid};
   assign w_rot  = NUM_REQ'(w_req2 >> r_ptr);

   always_comb begin
      w_req_any = 1'b0;
      w_req_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_req_any = 1'b1;
            w_req_idx = PTR_W'((int'(r_ptr) + i) % NUM_REQ);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_gidx_nxt  = r_gidx;
      w_stall_nxt = r_stall;
      w_gap_nxt   = r_gap;
      w_abort_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req_any) begin
               w_gidx_nxt  = w_req_idx;
               w_stall_nxt = '0;
               w_state_nxt = S_XFER;
            end
         end
         S_XFER: begin
            if (w_beat) begin
               w_stall_nxt = '0;
               if (i_last[r_gidx]) begin
                  w_ptr_nxt   = w_ptr_inc;
                  w_gap_nxt   = '0;
                  w_state_nxt = S_IFG;
               end
            end else if (!w_gvalid) begin
               // Backpressure (valid high, ready low) never counts as a stall.
               if (r_stall == STALL_LAST) begin
                  w_abort_nxt = 1'b1;
                  w_ptr_nxt   = w_ptr_inc;
                  w_gap_nxt   = '0;
                  w_state_nxt = S_IFG;
               end else begin
                  w_stall_nxt = r_stall + 1'b1;
               end
            end
         end
         S_IFG: begin
            if (r_gap == GAP_LAST) begin
               // Arbitrate on the cycle the gap ends so a waiting source gets
               // its grant IFG_CYCLES+1 cycles after the last beat.
               if (w_req_any) begin
                  w_gidx_nxt  = w_req_idx;
                  w_stall_nxt = '0;
                  w_state_nxt = S_XFER;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_gap_nxt = r_gap + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_gidx  <= '0;
         r_stall <= '0;
         r_gap   <= '0;
         r_abort <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_gidx  <= w_gidx_nxt;
         r_stall <= w_stall_nxt;
         r_gap   <= w_gap_nxt;
         r_abort <= w_abort_nxt;
      end
   end

endmodule
